axi4_lite_slave_regfile: RTL and testbench

AXI4-Lite slave register file: the downstream endpoint for the team's AXI4-Lite master. It accepts write address and write data on independent channels in either order, commits byte-strobed writes into NUM_REGS registers and returns a write response. It also serves single-beat reads. The register contents are exported flat for use by the core logic.

---
 rtl/axi4_lite_slave_regfile_if.sv | 38 +++
 rtl/axi4_lite_slave_regfile.sv | 107 ++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bundle between the register file and its master.
// The master modport drives requests; the slave modport answers them.
interface axi4_lite_slave_regfile_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) ();
  logic [ADDRESS_WIDTH-1:0]  AWADDR;
  logic [2:0]                AWPROT;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDRESS_WIDTH-1:0]  ARADDR;
  logic [2:0]                ARPROT;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register file: byte-strobed writes, single-beat reads, flat register export.
// Define AXI_LITE_SLV_DECERR_EN to answer out-of-range accesses with DECERR.
module axi4_lite_slave_regfile #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned NUM_REGS      = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi4_lite_slave_regfile_if.slave       bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);
  localparam int unsigned IDX_WIDTH  = ADDRESS_WIDTH - 2;
  localparam int unsigned SEL_WIDTH  = $clog2(NUM_REGS);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
`ifdef AXI_LITE_SLV_DECERR_EN
  localparam logic [1:0] oor_resp = 2'b11;
`else
  localparam logic [1:0] oor_resp = 2'b00;
`endif

  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
  logic                     aw_held, w_held;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0]    w_data;
  logic [STRB_WIDTH-1:0]    w_strb;
  logic                     b_valid, r_valid;
  logic [1:0]               b_resp, r_resp;
  logic [DATA_WIDTH-1:0]    r_data;

  logic [IDX_WIDTH-1:0]     w_idx, r_idx;
  logic                     w_in_range, r_in_range;
  logic                     aw_hs, w_hs, ar_hs, commit;

  assign w_idx      = aw_addr[ADDRESS_WIDTH-1:2];
  assign r_idx      = bus.ARADDR[ADDRESS_WIDTH-1:2];
  assign w_in_range = w_idx < IDX_WIDTH'(NUM_REGS);
  assign r_in_range = r_idx < IDX_WIDTH'(NUM_REGS);

  // Readies depend on state only, never on the incoming VALIDs.
  assign bus.AWREADY = !aw_held && !b_valid;
  assign bus.WREADY  = !w_held && !b_valid;
  assign bus.ARREADY = !r_valid;

  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign w_hs   = bus.WVALID && bus.WREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign commit = aw_held && w_held && !b_valid;

  assign bus.BVALID = b_valid;
  assign bus.BRESP  = b_resp;
  assign bus.RVALID = r_valid;
  assign bus.RRESP  = r_resp;
  assign bus.RDATA  = r_data;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      b_valid <= 1'b0;
      b_resp  <= 2'b00;
      r_valid <= 1'b0;
      r_resp  <= 2'b00;
      r_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr <= bus.AWADDR;
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        w_data <= bus.WDATA;
        w_strb <= bus.WSTRB;
        w_held <= 1'b1;
      end
      if (b_valid && bus.BREADY) b_valid <= 1'b0;
      if (commit) begin
        if (w_in_range) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb[b]) regs[w_idx[SEL_WIDTH-1:0]][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
        b_valid <= 1'b1;
        b_resp  <= w_in_range ? 2'b00 : oor_resp;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (r_valid && bus.RREADY) r_valid <= 1'b0;
      // Non-blocking read of regs yields the pre-commit value on a same-edge collision.
      if (ar_hs) begin
        r_data  <= r_in_range ? regs[r_idx[SEL_WIDTH-1:0]] : '0;
        r_resp  <= r_in_range ? 2'b00 : oor_resp;
        r_valid <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  logic unused_bits;
  assign unused_bits = ^{bus.AWPROT, bus.ARPROT, aw_addr[1:0], bus.ARADDR[1:0]};
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile with a response scoreboard and a register model.
module tb_axi4_lite_slave_regfile;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 16;
  localparam int unsigned FW = NR * DW;
`ifdef AXI_LITE_SLV_DECERR_EN
  localparam logic [1:0] oor_resp = 2'b11;
`else
  localparam logic [1:0] oor_resp = 2'b00;
`endif

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [FW-1:0] regs_flat;

  axi4_lite_slave_regfile_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave_regfile #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .NUM_REGS     (NR)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .bus      (bus),
    .regs_flat(regs_flat)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wr_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rsp_t;

  rsp_t        bq[$];
  rsp_t        rq[$];
  wr_t         pq[$];
  logic [31:0] model [NR];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a[31:2] < 30'(NR);
  endfunction

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  // Model is updated only when the response arrives, i.e. at commit.
  task automatic post_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
    rsp_t e;
    wr_t  w;
    w.addr = addr;
    w.data = data;
    w.strb = strb;
    pq.push_back(w);
    e.data = '0;
    e.resp = in_range(addr) ? 2'b00 : oor_resp;
    bq.push_back(e);
  endtask

  task automatic apply_write();
    wr_t w;
    int  idx;
    w = pq.pop_front();
    if (in_range(w.addr)) begin
      idx = int'(w.addr[31:2]);
      for (int b = 0; b < 4; b++) if (w.strb[b]) model[idx][8*b +: 8] = w.data[8*b +: 8];
    end
  endtask

  task automatic write_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n = 0;
    while (!(bus.AWREADY && bus.WREADY) && n < 20) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", FW'(n < 20), FW'(1));
    bus.AWADDR  = addr;
    bus.WDATA   = data;
    bus.WSTRB   = strb;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    post_write(addr, data, strb);
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
  endtask

  task automatic read_req(input logic [31:0] addr);
    rsp_t e;
    int   n = 0;
    while (!bus.ARREADY && n < 20) begin
      tick();
      n++;
    end
    chk("rd_ready_wait", FW'(n < 20), FW'(1));
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    e.data = in_range(addr) ? model[int'(addr[31:2])] : 32'h0;
    e.resp = in_range(addr) ? 2'b00 : oor_resp;
    rq.push_back(e);
    tick();
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_b(input string tag, input int lat, input int hold);
    rsp_t e;
    int   n = 0;
    bus.BREADY = (hold == 0);
    while (!bus.BVALID && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_blat"}, FW'(n), FW'(lat));
    if (bq.size() > 0) e = bq.pop_front();
    else e = '1;
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_bhold"}, FW'({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}),
          FW'({1'b1, e.resp, 2'b00}));
      tick();
    end
    bus.BREADY = 1'b1;
    chk({tag, "_bresp"}, FW'(bus.BRESP), FW'(e.resp));
    if (pq.size() > 0) apply_write();
    chk({tag, "_regs"}, regs_flat, model_flat());
    tick();
    chk({tag, "_bclr"}, FW'(bus.BVALID), FW'(0));
  endtask

  task automatic wait_r(input string tag, input int lat, input int hold);
    rsp_t e;
    int   n = 0;
    bus.RREADY = (hold == 0);
    while (!bus.RVALID && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rlat"}, FW'(n), FW'(lat));
    if (rq.size() > 0) e = rq.pop_front();
    else e = '1;
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_rhold"}, FW'({bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY}),
          FW'({1'b1, e.data, e.resp, 1'b0}));
      tick();
    end
    bus.RREADY = 1'b1;
    chk({tag, "_rdata"}, FW'({bus.RDATA, bus.RRESP}), FW'({e.data, e.resp}));
    tick();
    chk({tag, "_rclr"}, FW'(bus.RVALID), FW'(0));
  endtask

  initial begin
    logic [31:0] val;
    ARESET      = 1'b1;
    bus.AWADDR  = '0;
    bus.AWPROT  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b1;
    bus.ARADDR  = '0;
    bus.ARPROT  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick();
    tick();
    ARESET = 1'b0;

    chk("rst_valid", FW'({bus.BVALID, bus.RVALID}), FW'(0));
    chk("rst_ready", FW'({bus.AWREADY, bus.WREADY, bus.ARREADY}), FW'(3'b111));
    chk("rst_resp", FW'({bus.BRESP, bus.RRESP, bus.RDATA}), FW'(0));
    chk("rst_regs", regs_flat, FW'(0));

    // Basic write and read-back.
    write_req(32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_b("basic", 1, 0);
    chk("basic_reg1", FW'(regs_flat[63:32]), FW'(32'hDEAD_BEEF));
    read_req(32'h0000_0004);
    wait_r("basic", 0, 0);

    // Partial strobe keeps the upper half.
    write_req(32'h0000_0004, 32'h1234_5678, 4'b0011);
    wait_b("strb", 1, 0);
    read_req(32'h0000_0004);
    wait_r("strb", 0, 0);

    // W three cycles ahead of AW.
    bus.WDATA  = 32'hA5A5_A5A5;
    bus.WSTRB  = 4'hF;
    bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("wfirst_gap", FW'({bus.WREADY, bus.AWREADY}), FW'(2'b01));
      tick();
    end
    bus.AWADDR  = 32'h0000_0008;
    bus.AWVALID = 1'b1;
    post_write(32'h0000_0008, 32'hA5A5_A5A5, 4'hF);
    chk("wfirst_gap", FW'({bus.WREADY, bus.AWREADY}), FW'(2'b01));
    tick();
    bus.AWVALID = 1'b0;
    wait_b("wfirst", 1, 0);
    chk("wfirst_reg2", FW'(regs_flat[95:64]), FW'(32'hA5A5_A5A5));

    // Backpressure on both response channels.
    write_req(32'h0000_000C, 32'hCAFE_F00D, 4'hF);
    wait_b("bp", 1, 5);
    read_req(32'h0000_000C);
    wait_r("bp", 0, 5);

    // Out-of-range accesses.
    write_req(32'h0000_0040, 32'hFFFF_FFFF, 4'hF);
    wait_b("oor", 1, 0);
    read_req(32'h0000_0040);
    wait_r("oor", 0, 0);

    // Read colliding with a commit to the same register sees the old value.
    bus.RREADY = 1'b0;
    write_req(32'h0000_0004, 32'h0BAD_F00D, 4'hF);
    read_req(32'h0000_0004);
    wait_b("col", 0, 0);
    wait_r("col", 0, 0);
    read_req(32'h0000_0004);
    wait_r("col_after", 0, 0);

    // Reset while B and R are both pending.
    bus.BREADY = 1'b0;
    bus.RREADY = 1'b0;
    write_req(32'h0000_0010, 32'h1111_2222, 4'hF);
    read_req(32'h0000_0004);
    chk("mid_pending", FW'({bus.BVALID, bus.RVALID}), FW'(2'b11));
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    bq.delete();
    rq.delete();
    pq.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("mid_valid", FW'({bus.BVALID, bus.RVALID}), FW'(0));
    chk("mid_ready", FW'({bus.AWREADY, bus.WREADY, bus.ARREADY}), FW'(3'b111));
    chk("mid_regs", regs_flat, FW'(0));
    bus.BREADY = 1'b1;
    bus.RREADY = 1'b1;

    // Recovery: top register, random data.
    val = $urandom;
    write_req(32'h0000_003C, val, 4'b1010);
    wait_b("post", 1, 0);
    read_req(32'h0000_003C);
    wait_r("post", 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
